mem_arbiter: RTL
================

# mem_arbiter

Shares a single-port memory bus between instruction fetch and the memory-map (MM) stage's data loads and stores. Data requests normally take priority, and a starvation counter guarantees fetch progress. The block also handles byte-lane formatting: it generates strobes, replicates store data, and extracts and sign- or zero-extends load data. It sits between the pipeline's fetch/MM stages and the memory/MMIO interconnect, with one transaction outstanding at a time.

## Interface
- `STARVE_MAX`, 4: consecutive data grants allowed while `if_req` waits before fetch wins (≥1).
- `clk` in 1: core clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request, held until granted.
- `if_addr` in `word_t`: fetch address (bits [1:0] ignored).
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse, `if_rdata` valid.
- `if_rdata` out `word_t`: instruction word.
- `dm_req` in 1: data request, held until granted.
- `dm_fun` in `fun_t`: LOAD_* or STORE_*.
- `dm_addr` in `word_t`: byte address.
- `dm_wdata` in `word_t`: store data, low-aligned.
- `dm_gnt` out 1: data request accepted this cycle.
- `dm_rvalid` out 1: one-cycle completion pulse for loads, stores and faults.
- `dm_rdata` out `word_t`: extended load data; 0 for stores and faults.
- `dm_err` out 1: qualifies `dm_rvalid`; misaligned or non-memory `fun`.
- `mem_valid` out 1: bus request, held until `mem_ready`.
- `mem_ready` in 1: bus accepts/completes this cycle.
- `mem_write` out 1: 1 for store.
- `mem_addr` out `word_t`: word-aligned address `{addr[31:2],2'b00}`.
- `mem_strb` out `strb_t`: write byte enables; 0000 for reads.
- `mem_wdata` out `word_t`: lane-replicated store data.
- `mem_rdata` in `word_t`: read data, valid with `mem_ready` when `mem_write`=0.

## Operation
- FSM states: IDLE, INST, DATA, FAULT. Reset state is IDLE.
- **IDLE:** grants are combinational and issued only in this state.
  - Arbitration: data wins if `dm_req` and (`starve_cnt` < `STARVE_MAX` or !`if_req`); otherwise fetch wins if `if_req`.
  - Fetch grant: `if_gnt`=1, capture the request, go to INST.
  - Valid data grant: `dm_gnt`=1, capture, go to DATA.
  - Faulting data grant: `dm_gnt`=1, go to FAULT, no bus cycle. A data request faults if `fun` is not load/store (use package `is_load`/`is_store`), or if WORD has `addr[1:0]`≠0, or if HALF/HALF_UNSIGNED has `addr[0]`≠0.
- **Starvation counter:**
  - Increments on each data grant while `if_req`=1, saturating at `STARVE_MAX`.
  - Clears on a fetch grant.
  - Unchanged otherwise.
- **INST / DATA:** `mem_valid`=1 with the registered fields. On `mem_ready`, latch the formatted response, pulse the owner's `rvalid` next cycle, and return to IDLE.
- **FAULT:** one cycle. `dm_rvalid`=1, `dm_err`=1, `dm_rdata`=0; then IDLE.
- **Store lanes:**
  - WORD: strb 1111, wdata as given.
  - HALF: strb 0011<<(2·addr[1]), wdata `{2{wdata[15:0]}}`.
  - BYTE: strb 0001<<addr[1:0], wdata `{4{wdata[7:0]}}`.
- **Load lanes:** shift `mem_rdata` right by 8·addr[1:0]. Sign-extend for LOAD_HALF and LOAD_BYTE; zero-extend for the _UNSIGNED variants.
- **Reset values:** all outputs 0, `starve_cnt`=0.
- **Reset mid-transaction:** `mem_valid` drops immediately and the transaction is abandoned with no `rvalid`. The interconnect shares `resetn`.
- Requests arriving outside IDLE wait; no queuing.
- `mem_ready` while `mem_valid`=0 is ignored.

## Timing
- Cycle 0: `gnt` (IDLE).
- Cycle 1 onward: `mem_valid` asserted, until `mem_ready` at cycle k≥1.
- Cycle k+1: `rvalid`, and state is IDLE, so a new grant is possible in that same cycle.
- With zero-wait memory (k=1): 2 cycles/transaction; fault path: 2 cycles.
- `mem_*` outputs, `rvalid`, `rdata` and `err` are registered. `gnt` is combinational from `req`, state and `starve_cnt`.
- Simultaneous `if_req` and `dm_req`: resolved by the arbitration rule only, deterministically.

## Structure
- Add to the shared `core` package:
  - `arb_state_t` enum {IDLE, INST, DATA, FAULT}.
  - Functions `lane_strb(fun_t, logic[1:0])`, `lane_wdata(fun_t, word_t)`, `lane_rdata(fun_t, logic[1:0], word_t)`, `is_misaligned(fun_t, logic[1:0])`.
- Sub-module `mem_lane`: combinational strobe/replicate/extract/extend wrapper around these functions. It is reused by a future MMIO bridge.

## Test plan
- Store byte, `addr` 0x103, `wdata` 0xAB, zero-wait → `mem_addr` 0x100, `strb` 1000, `mem_wdata` 0xABABABAB; `dm_rvalid` at cycle 2, `dm_rdata` 0.
- Loads from word 0x80F0_1234 at 0x40: LOAD_HALF @0x42 → 0xFFFF80F0; LOAD_BYTE_UNSIGNED @0x43 → 0x00000080; LOAD_WORD @0x40 → 0x80F01234.
- Misaligned LOAD_WORD @0x41, and `fun`=REGISTER → `dm_gnt`, no `mem_valid`, next cycle `dm_rvalid`=`dm_err`=1.
- `if_req` and `dm_req` held high continuously, `STARVE_MAX`=4 → grant sequence D,D,D,D,I,D,D,D,D,I…
- `mem_ready` delayed 5 cycles, `if_req` raised mid-wait → `mem_valid` steady 5 cycles, fields stable, `if_gnt` only after `dm_rvalid`.
- `resetn` low during DATA with `mem_valid`=1 → `mem_valid` 0 asynchronously; no `dm_rvalid`; after release, first `if_req` granted in IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared core types and byte-lane helpers for the memory arbiter
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [3:0] {
    REGISTER,
    LOAD_BYTE,
    LOAD_HALF,
    LOAD_WORD,
    LOAD_BYTE_UNSIGNED,
    LOAD_HALF_UNSIGNED,
    STORE_BYTE,
    STORE_HALF,
    STORE_WORD
  } fun_t;

  typedef enum logic [1:0] {IDLE, INST, DATA, FAULT} arb_state_t;

  function automatic logic is_load(fun_t f);
    return f inside {LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_UNSIGNED, LOAD_HALF_UNSIGNED};
  endfunction

  function automatic logic is_store(fun_t f);
    return f inside {STORE_BYTE, STORE_HALF, STORE_WORD};
  endfunction

  function automatic strb_t lane_strb(fun_t f, logic [1:0] off);
    strb_t s;
    s = 4'b0000;
    case (f)
      STORE_WORD: s = 4'b1111;
      STORE_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      STORE_BYTE: s = 4'b0001 << off;
      default:    s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic word_t lane_wdata(fun_t f, word_t w);
    word_t v;
    v = w;
    case (f)
      STORE_HALF: v = {2{w[15:0]}};
      STORE_BYTE: v = {4{w[7:0]}};
      default:    v = w;
    endcase
    return v;
  endfunction

  // Halves are only ever half-aligned here, so off[1] alone picks the half.
  function automatic word_t lane_rdata(fun_t f, logic [1:0] off, word_t r);
    word_t       v;
    logic [7:0]  b;
    logic [15:0] h;
    b = r[{off, 3'b000} +: 8];
    h = r[{off[1], 4'b0000} +: 16];
    v = '0;
    case (f)
      LOAD_WORD:          v = r;
      LOAD_HALF:          v = {{16{h[15]}}, h};
      LOAD_HALF_UNSIGNED: v = {16'h0000, h};
      LOAD_BYTE:          v = {{24{b[7]}}, b};
      LOAD_BYTE_UNSIGNED: v = {24'h000000, b};
      default:            v = '0;
    endcase
    return v;
  endfunction

  function automatic logic is_misaligned(fun_t f, logic [1:0] off);
    logic m;
    m = 1'b0;
    case (f)
      LOAD_WORD, STORE_WORD:                      m = (off != 2'b00);
      LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF:  m = off[0];
      default:                                    m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_arbiter_lane.sv
// rtl/mem_arbiter_lane.sv - mem_lane: combinational strobe/replicate/extract/extend wrapper
module mem_lane
  import mem_arbiter_pkg::*;
(
  input  logic [3:0]  req_fun,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_strb,
  output logic [31:0] req_wdata_rep,
  output logic        req_fault,
  input  logic [3:0]  rsp_fun,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_rdata_ext
);

  fun_t req_fun_e;
  fun_t rsp_fun_e;

  assign req_fun_e = fun_t'(req_fun);
  assign rsp_fun_e = fun_t'(rsp_fun);

  assign req_strb      = lane_strb(req_fun_e, req_off);
  assign req_wdata_rep = lane_wdata(req_fun_e, req_wdata);
  // Anything that is neither a load nor a store never reaches the bus.
  assign req_fault     = !(is_load(req_fun_e) || is_store(req_fun_e))
                         || is_misaligned(req_fun_e, req_off);
  assign rsp_rdata_ext = lane_rdata(rsp_fun_e, rsp_off, rsp_rdata);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory bus arbiter between fetch and data with starvation guard
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [3:0]  dm_fun,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_strb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  fun_t          fun_q, fun_d;
  logic [1:0]    off_q, off_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_write_q, mem_write_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_strb_q, mem_strb_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          dm_rvalid_q, dm_rvalid_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          dm_err_q, dm_err_d;

  fun_t          dm_fun_e;
  logic          dm_win;
  logic [3:0]    req_strb;
  logic [31:0]   req_wdata_rep;
  logic          req_fault;
  logic [31:0]   rsp_rdata_ext;

  assign dm_fun_e = fun_t'(dm_fun);

  mem_lane u_lane (
    .req_fun       (dm_fun),
    .req_off       (dm_addr[1:0]),
    .req_wdata     (dm_wdata),
    .req_strb      (req_strb),
    .req_wdata_rep (req_wdata_rep),
    .req_fault     (req_fault),
    .rsp_fun       (fun_q),
    .rsp_off       (off_q),
    .rsp_rdata     (mem_rdata),
    .rsp_rdata_ext (rsp_rdata_ext)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    fun_d       = fun_q;
    off_d       = off_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_strb_d  = mem_strb_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rvalid_d = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    dm_err_d    = 1'b0;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    dm_win      = 1'b0;

    case (state_q)
      IDLE: begin
        // Data normally wins; once it has won STARVE_MAX times over a waiting fetch, fetch goes next.
        dm_win = dm_req && ((starve_q < STARVE_LIM) || !if_req);
        if (dm_win) begin
          dm_gnt = 1'b1;
          if (if_req && (starve_q != STARVE_LIM)) starve_d = starve_q + 1'b1;
          if (req_fault) begin
            state_d     = FAULT;
            dm_rvalid_d = 1'b1;
            dm_err_d    = 1'b1;
            dm_rdata_d  = '0;
          end else begin
            state_d     = DATA;
            mem_valid_d = 1'b1;
            mem_write_d = is_store(dm_fun_e);
            mem_addr_d  = dm_addr & 32'hFFFF_FFFC;
            mem_strb_d  = req_strb;
            mem_wdata_d = req_wdata_rep;
            fun_d       = dm_fun_e;
            off_d       = dm_addr[1:0];
          end
        end else if (if_req) begin
          if_gnt      = 1'b1;
          starve_d    = '0;
          state_d     = INST;
          mem_valid_d = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = if_addr & 32'hFFFF_FFFC;
          mem_strb_d  = 4'b0000;
          mem_wdata_d = '0;
        end
      end
      INST: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
          state_d     = IDLE;
        end
      end
      DATA: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = rsp_rdata_ext;
          state_d     = IDLE;
        end
      end
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      fun_q       <= REGISTER;
      off_q       <= 2'b00;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_strb_q  <= 4'b0000;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      fun_q       <= fun_d;
      off_q       <= off_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_strb_q  <= mem_strb_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_err_q    <= dm_err_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_strb  = mem_strb_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_err    = dm_err_q;

endmodule
